// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the 24-bit CPU: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Define ILLEGAL_TRAP_EN to make illegal opcodes trap permanently.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic [3:0]       dbg_state
);

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_J    = 4'h7;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t state, state_nxt;
  logic   retire;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:           state_nxt = S_EXEC_R;
          OP_ADDI, OP_MUL: state_nxt = S_EXEC_I;
          OP_LW, OP_SW:   state_nxt = S_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:           state_nxt = S_JUMP;
          default:        state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: state_nxt = S_WB_R;
      S_EXEC_I: state_nxt = S_WB_I;
      S_ADDR:   state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_nxt = S_WB_MEM;
      S_MEM_WR: if (mem_ready) begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_nxt = S_TRAP;
`else
        // Illegal opcode behaves as a NOP that still counts as retired.
        state_nxt = S_FETCH;
        retire    = 1'b1;
`endif
      end
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Outputs are forced to zero while reset is high so no strobe fires during an abort.
  always_comb begin
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b10;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB_R: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_WB_MEM: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_write  = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: drivers push hand-computed per-cycle output words into a queue,
// a negedge monitor pops and compares them against the DUT. Honors ILLEGAL_TRAP_EN if defined.
module tb_multicycle_control;

  localparam int CNT_W = 8;
  localparam int W     = CNT_W + 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       alu_op;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic [3:0]       dbg_state;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .retired(retired), .illegal(illegal), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0]     exp_q[$];
  string            tag_q[$];
  logic [CNT_W-1:0] exp_ret;
  int               vectors = 0;
  int               miscompares = 0;

  // Output word: alu_op, src_a, src_b, iord, mem_read, mem_write, ir_write, pc_write, pc_src,
  // reg_dst, mem_to_reg, reg_write, illegal.
  function automatic logic [15:0] ow(input logic [1:0] aop, input logic sa, input logic [1:0] sb,
                                     input logic id, input logic mrd, input logic mwr,
                                     input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic ill);
    return {aop, sa, sb, id, mrd, mwr, irw, pcw, pcs, rd, m2r, rw, ill};
  endfunction

  localparam logic [15:0] O_ZERO   = 16'h0000;
  logic [15:0] o_fetch1, o_fetch0, o_dec, o_exr, o_exi, o_addr, o_memrd, o_memwr;
  logic [15:0] o_wbr, o_wbi, o_wbmem, o_br1, o_br0, o_jump, o_trap;

  initial begin
    o_fetch1 = ow(2'b00, 0, 2'b01, 0, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0);
    o_fetch0 = ow(2'b00, 0, 2'b01, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    o_dec    = ow(2'b00, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    o_exr    = ow(2'b10, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    o_exi    = ow(2'b11, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    o_addr   = ow(2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    o_memrd  = ow(2'b00, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    o_memwr  = ow(2'b00, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    o_wbr    = ow(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0);
    o_wbi    = ow(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    o_wbmem  = ow(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    o_br1    = ow(2'b01, 1, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0);
    o_br0    = ow(2'b01, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    o_jump   = ow(2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    o_trap   = ow(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
`else
    o_trap   = O_ZERO;
`endif
  end

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_w, act_w;
      string        tag;
      exp_w = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act_w = {retired, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
               pc_write, pc_src, reg_dst, mem_to_reg, reg_write, illegal};
      vectors++;
      if (act_w !== exp_w) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", tag, act_w, exp_w);
      end
    end
  end

  // driver tasks: inputs are set at posedge+1, expectation covers that cycle
  task automatic cyc(input logic [15:0] o, input string tag);
    exp_q.push_back({exp_ret, o});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch();
    mem_ready = 1'b1;
    cyc(o_fetch1, "fetch");
    cyc(o_dec, "decode");
  endtask

  task automatic run_r();
    opcode = 4'h0;
    do_fetch();
    cyc(o_exr, "exec_r");
    cyc(o_wbr, "wb_r");
    exp_ret++;
  endtask

  task automatic run_j();
    opcode = 4'h7;
    do_fetch();
    cyc(o_jump, "jump");
    exp_ret++;
  endtask

  initial begin
    rst = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b1; exp_ret = '0;
    @(posedge clk);
    #1;
    cyc(O_ZERO, "reset_hold");
    cyc(O_ZERO, "reset_hold");
    rst = 1'b0;

    // R-format, 4 cycles
    run_r();

    // Fetch stall with MemReady low, then ADDI
    opcode = 4'h1; mem_ready = 1'b0;
    cyc(o_fetch0, "fetch_stall");
    do_fetch();
    cyc(o_exi, "exec_i_addi");
    cyc(o_wbi, "wb_i_addi");
    exp_ret++;

    // LW with two wait cycles in MEM_RD: 7 cycles
    opcode = 4'h2;
    do_fetch();
    cyc(o_addr, "addr_lw");
    mem_ready = 1'b0;
    cyc(o_memrd, "mem_rd_wait1");
    cyc(o_memrd, "mem_rd_wait2");
    mem_ready = 1'b1;
    cyc(o_memrd, "mem_rd_done");
    cyc(o_wbmem, "wb_mem");
    exp_ret++;

    // Branches
    opcode = 4'h4; zero = 1'b1;
    do_fetch();
    cyc(o_br1, "beq_taken");
    exp_ret++;
    opcode = 4'h5; zero = 1'b1;
    do_fetch();
    cyc(o_br0, "bne_not_taken");
    exp_ret++;
    opcode = 4'h5; zero = 1'b0;
    do_fetch();
    cyc(o_br1, "bne_taken");
    exp_ret++;
    opcode = 4'h4; zero = 1'b0;
    do_fetch();
    cyc(o_br0, "beq_not_taken");
    exp_ret++;

    // MUL (I-format)
    opcode = 4'h6;
    do_fetch();
    cyc(o_exi, "exec_i_mul");
    cyc(o_wbi, "wb_i_mul");
    exp_ret++;

    // SW, single MEM_WR cycle
    opcode = 4'h3;
    do_fetch();
    cyc(o_addr, "addr_sw");
    cyc(o_memwr, "mem_wr");
    exp_ret++;

    // Illegal opcode
    opcode = 4'hA;
    do_fetch();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      cyc(o_trap, "trap_hold");
    end
    rst = 1'b1;
    exp_ret = '0;
    cyc(O_ZERO, "trap_reset");
    rst = 1'b0;
`else
    cyc(o_trap, "trap_nop");
    exp_ret++;
`endif
    run_r();

    // Drive Retired to all-ones with jumps, then one more wraps to zero
    while (exp_ret != {CNT_W{1'b1}}) run_j();
    run_j();

    // SW held in MEM_WR, then reset aborts it
    opcode = 4'h3;
    do_fetch();
    cyc(o_addr, "addr_sw2");
    mem_ready = 1'b0;
    cyc(o_memwr, "mem_wr_hold");
    rst = 1'b1;
    exp_ret = '0;
    cyc(O_ZERO, "reset_in_mem_wr");
    rst = 1'b0;
    run_r();

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout: bench still running at %0t, limit 200000", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the 24-bit CPU. It is the producing end of the ALUOp interface that the ALU control decoder consumes.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK from the 4-bit opcode.
- Drives ALUOp, datapath mux selects, memory strobes and register-file write enable.
- Sits between the instruction register and the datapath; stalls on a memory ready handshake.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high
- Opcode  input  4  instruction-register bits [23:20]
- Zero  input  1  ALU zero flag, sampled in BRANCH state
- MemReady  input  1  memory completes the current read/write this cycle
- ALUOp  output  2  00 add (lw/sw/PC+1), 01 sub (beq/bne), 10 R-format (Funct decoded downstream), 11 I-format
- ALUSrcA  output  1  0=PC, 1=register A
- ALUSrcB  output  2  00=reg B, 01=constant 1, 10=sign-extended imm
- IorD  output  1  0=instruction address, 1=data address
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  load instruction register
- PCWrite  output  1  load PC
- PCSrc  output  2  00=ALU result, 01=branch target (ALUOut), 10=jump target
- RegDst  output  1  0=rt, 1=rd
- MemToReg  output  1  0=ALUOut, 1=MDR
- RegWrite  output  1  register-file write enable
- Retired  output  CNT_W  count of completed instructions
- Illegal  output  1  illegal-opcode indicator

Behaviour:
- Opcode map:
  - 0000 R-format
  - 0001 ADDI
  - 0010 LW
  - 0011 SW
  - 0100 BEQ
  - 0101 BNE
  - 0110 MUL (I-format)
  - 0111 J
  - 1000–1111 illegal
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
- Reset (async), and any output whose value is not listed for a state, returns to:
  - state = FETCH; Retired = 0; Illegal = 0
  - all strobes 0; ALUOp = 00; all selects 0
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite equal MemReady. Stay in FETCH while MemReady=0; go to DECODE on MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=10, ALUOp=00 (precompute branch target).
  - Next state by Opcode: R→EXEC_R; ADDI, MUL→EXEC_I; LW, SW→ADDR; BEQ, BNE→BRANCH; J→JUMP; illegal→TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 → WB_I.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1. Hold until MemReady → WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Hold until MemReady → FETCH; retires.
- WB_R: RegDst=1, MemToReg=0, RegWrite=1 → FETCH; retires.
- WB_I: RegDst=0, MemToReg=0, RegWrite=1 → FETCH; retires.
- WB_MEM: RegDst=0, MemToReg=1, RegWrite=1 → FETCH; retires.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - PCWrite = Zero for BEQ, ~Zero for BNE. → FETCH; retires.
- JUMP: PCSrc=10, PCWrite=1 → FETCH; retires.
- Cycle counts with MemReady tied high:
  - R, ADDI, MUL, SW: 4
  - LW: 5
  - BEQ, BNE, J: 3
  - Each MemReady-low cycle in FETCH or a MEM state adds one cycle.
- Retired counting:
  - Increments by 1 on the final cycle of each instruction.
  - Wraps from all-ones to 0 with no flag.
- Opcode is the IR output, so it is stable from DECODE onward; the FSM does not register it separately.
- Outputs are combinational from state (Moore), except PCWrite/IRWrite in FETCH (MemReady) and PCWrite in BRANCH (Zero).
- Reset asserted mid-instruction aborts it immediately; no write strobe is asserted after Reset rises.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - TRAP is absorbing; Illegal=1; all strobes 0.
  - Only Reset exits TRAP. Retired does not increment.
- Not defined:
  - TRAP lasts one cycle with no strobes, then goes to FETCH; the instruction executes as a NOP.
  - Retired increments; Illegal stays 0.

Test Plan:
- Reset with MemReady=1, Opcode=0000 → FETCH, DECODE, EXEC_R (ALUOp=10), WB_R (RegWrite=1, RegDst=1); Retired=1 after 4 cycles.
- Opcode=0010, MemReady low for 2 cycles in MEM_RD → LW completes in 7 cycles; WB_MEM asserts MemToReg=1, RegWrite=1.
- Opcode=0100 with Zero=1 → PCWrite=1 in BRANCH; Opcode=0101 with Zero=1 → PCWrite=0; both have ALUOp=01 and take 3 cycles.
- Opcode=0110 → ALUOp=11 in EXEC_I, RegDst=0 in WB_I; Opcode=0011 → MemWrite=1 for exactly one cycle with MemReady=1.
- Opcode=1010:
  - With ILLEGAL_TRAP_EN: Illegal=1 held for 20 cycles; Reset clears to FETCH, Illegal=0.
  - Without it: returns to FETCH in 3 cycles, Retired increments.
- Force Retired to all-ones via 65535 J instructions, then one more → Retired=0; Reset asserted during MEM_WR → MemWrite drops in the same cycle.
